// File: rtl/tspi_pkg.sv
// Shared definitions for the tspi SPI master: register offsets, FSM states
// and the STATUS register layout.
package tspi_pkg;

    localparam int AddrWidth   = 5;
    localparam int FrameBits   = 8;
    localparam int HalfPeriods = 2 * FrameBits;

    localparam logic [AddrWidth-1:0] CtrlOffset   = 5'h00;
    localparam logic [AddrWidth-1:0] DivOffset    = 5'h04;
    localparam logic [AddrWidth-1:0] TxdataOffset = 5'h08;
    localparam logic [AddrWidth-1:0] RxdataOffset = 5'h0C;
    localparam logic [AddrWidth-1:0] StatusOffset = 5'h10;

    localparam int StatusBusyBit    = 0;
    localparam int StatusRxValidBit = 1;
    localparam int StatusTxOvrBit   = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LINGER
    } tspi_state_e;

    typedef struct packed {
        logic [28:0] rsvd;
        logic        tx_ovr;
        logic        rx_valid;
        logic        busy;
    } status_t;

endpackage

// File: rtl/tspi_if.sv
// Register bus between the core (master) and the tspi peripheral (slave).
interface tspi_if;
    import tspi_pkg::*;

    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic                 gnt;
    logic                 rvalid;
    logic [31:0]          rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/tspi_clk_div.sv
// Half-period counter: counts 0..div while enabled and emits a one-cycle
// tick on the last count of each half-period.
module tspi_clk_div #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en,
    input  logic             clear,
    input  logic [Width-1:0] div,
    output logic             tick
);

    logic [Width-1:0] cnt_q;

    assign tick = en && (cnt_q == div);

    // Counter wraps on tick so consecutive half-periods chain without gaps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/tspi_master.sv
// SPI master, mode 0, MSB first, 8-bit frames. Register file and frame FSM;
// the half-period timing comes from tspi_clk_div.
module tspi_master
    import tspi_pkg::*;
#(
    parameter int ClkDivWidth = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    tspi_if.slave bus,
    output logic tspi_clk_o,
    output logic tspi_mosi_o,
    input  logic tspi_miso_i,
    output logic tspi_cs_no
);

    localparam logic [3:0] LastHalf = 4'(HalfPeriods - 1);

    tspi_state_e state_q, state_d;

    logic                   keep_cs_q;
    logic [ClkDivWidth-1:0] div_q;
    logic [ClkDivWidth-1:0] div_lat_q;
    logic [7:0]             shreg_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   tx_ovr_q;
    logic [3:0]             half_q;

    logic tick;
    logic busy;
    logic wr, rd;
    logic ctrl_wr, div_wr, tx_wr, status_wr, rx_rd;
    logic start;
    logic keep_cs_next;
    logic rise, fall, frame_done;
    logic [31:0] rdata_d;
    status_t     status;
    logic        unused_wdata;

    assign bus.gnt = 1'b1;

    assign wr        = bus.req &  bus.we;
    assign rd        = bus.req & ~bus.we;
    assign ctrl_wr   = wr && (bus.addr == CtrlOffset);
    assign div_wr    = wr && (bus.addr == DivOffset);
    assign tx_wr     = wr && (bus.addr == TxdataOffset);
    assign status_wr = wr && (bus.addr == StatusOffset);
    assign rx_rd     = rd && (bus.addr == RxdataOffset);

    assign busy  = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    // A TXDATA write only starts a frame when the line is not busy (IDLE or LINGER).
    assign start = tx_wr && !busy;

    // LINGER reacts to the CTRL write itself so HOLD begins the next cycle.
    assign keep_cs_next = ctrl_wr ? bus.wdata[0] : keep_cs_q;

    assign unused_wdata = ^bus.wdata[31:8];

    tspi_clk_div #(
        .Width (ClkDivWidth)
    ) u_clk_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (busy),
        .clear  (!busy),
        .div    (div_lat_q),
        .tick   (tick)
    );

    // Frame state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus per-cycle SCLK edge strobes.
    always_comb begin
        state_d    = state_q;
        rise       = 1'b0;
        fall       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SETUP;
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!half_q[0]) rise = 1'b1;
                    else            fall = 1'b1;
                    if (half_q == LastHalf) begin
                        frame_done = 1'b1;
                        state_d    = keep_cs_q ? LINGER : HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) state_d = IDLE;
            end
            LINGER: begin
                if (start)              state_d = SHIFT;
                else if (!keep_cs_next) state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad outputs and shift register; one register serves TX (MSB out) and RX (LSB in).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tspi_clk_o  <= 1'b0;
            tspi_mosi_o <= 1'b0;
            tspi_cs_no  <= 1'b1;
            shreg_q     <= '0;
            div_lat_q   <= '0;
            half_q      <= '0;
        end else if (start) begin
            shreg_q     <= bus.wdata[7:0];
            div_lat_q   <= div_q;
            tspi_mosi_o <= bus.wdata[7];
            tspi_cs_no  <= 1'b0;
            half_q      <= '0;
        end else if (rise) begin
            tspi_clk_o <= 1'b1;
            shreg_q    <= {shreg_q[6:0], tspi_miso_i};
            half_q     <= half_q + 1'b1;
        end else if (fall) begin
            tspi_clk_o  <= 1'b0;
            // After the last bit the line returns low instead of presenting received data.
            tspi_mosi_o <= frame_done ? 1'b0 : shreg_q[7];
            half_q      <= half_q + 1'b1;
        end else if ((state_q == HOLD) && tick) begin
            tspi_cs_no <= 1'b1;
        end
    end

    // Software-visible registers; hardware set events win over software clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keep_cs_q  <= 1'b0;
            div_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ovr_q   <= 1'b0;
        end else begin
            keep_cs_q <= keep_cs_next;
            if (div_wr) div_q <= bus.wdata[ClkDivWidth-1:0];
            if (frame_done) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
            end else if (rx_rd) begin
                rx_valid_q <= 1'b0;
            end
            if (tx_wr && busy) begin
                tx_ovr_q <= 1'b1;
            end else if (status_wr && bus.wdata[StatusTxOvrBit]) begin
                tx_ovr_q <= 1'b0;
            end
        end
    end

    // Read data mux; TXDATA and unmapped offsets read as zero.
    always_comb begin
        status          = '0;
        status.busy     = busy;
        status.rx_valid = rx_valid_q;
        status.tx_ovr   = tx_ovr_q;
        rdata_d         = '0;
        case (bus.addr)
            CtrlOffset:   rdata_d = {31'b0, keep_cs_q};
            DivOffset:    rdata_d = 32'(div_q);
            RxdataOffset: rdata_d = {24'b0, rx_data_q};
            StatusOffset: rdata_d = status;
            default:      rdata_d = '0;
        endcase
    end

    // Single-cycle response for every request; write responses carry zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= bus.req;
            bus.rdata  <= rd ? rdata_d : '0;
        end
    end

endmodule
